execute_stage_mc: RTL
=====================

// Module: execute_stage_mc
// PURPOSE
//  Parametrised Y86 pipeline execute stage: ALU, condition codes, cond evaluation, E->M register.
//  Adds multi-cycle iterative mulq (OPq ifun 4) with valid/ready stall handshake both sides.
//  Sits between decode (E register fields) and memory stage; drives forwarding taps back to decode.
// PARAMETERS
//  DATA_W     64  datapath width (valA/valB/valC/valE)
//  MUL_EN     1   1: OPq ifun 4 = signed multiply; 0: ifun 4 -> stat INS (4)
//  STACK_STEP 8   rsp delta for call/push (-) and ret/pop (+)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous reset, active low
//  e_valid    in   1       E register holds an instruction
//  e_ready    out  1       stage accepts E this cycle
//  e_icode    in   4       icode
//  e_ifun     in   4       ifun
//  e_stat     in   4       1 AOK, 2 HLT, 3 ADR, 4 INS
//  e_valA/B/C in   DATA_W  operands
//  e_dstE/M   in   4       destination regs (4'hF = none)
//  m_exc/w_exc in  1       M/W stage stat != AOK (inhibit CC)
//  fwd_dstE   out  4       forward dest (4'hF if none / not accepted)
//  fwd_valE   out  DATA_W  forward value
//  fwd_valid  out  1       fwd_valE usable; 0 -> decode must stall on match
//  cc         out  3       {ZF,SF,OF}
//  M_valid    out  1       M register valid
//  m_ready    in   1       memory stage consumes M
//  M_icode,M_stat,M_cnd,M_valE,M_valA,M_dstE,M_dstM  out  4,4,1,DATA_W,DATA_W,4,4
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, M_valid 0, all M_* 0, cc 3'b100, counter 0.
//  Reset mid-multiply aborts it; no M write.
//  States: IDLE, MUL (iterating), DONE (product held).
//  e_ready = (state==IDLE) && (!M_valid || m_ready).
//  Accept = e_valid && e_ready.
//  Non-mul accept: M_* loaded next edge, 1-cycle latency.
//  Mul accept: IDLE->MUL; operands, sign latched.
//  MUL: DATA_W cycles, 1 bit per cycle, shift-add on magnitudes; then ->DONE with sign applied.
//  DONE: writes M when (!M_valid || m_ready), then ->IDLE. Mul latency = DATA_W+2 cycles min.
//  M_valid clears on m_ready with no new write; holds value while !m_ready.
//  valE: rrmov valA; irmov valC; rmmov/mrmov valB+valC; call/push valB-STACK_STEP;
//   ret/pop valB+STACK_STEP; OPq: 0 add B+A, 1 sub B-A, 2 and, 3 xor, 4 mul low DATA_W bits.
//  All arithmetic mod 2^DATA_W.
//  cnd (cmov/jXX) from cc by ifun: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g; ifun>6 -> stat INS.
//  cmov with cnd=0: M_dstE=4'hF.
//  CC written only for OPq when e_stat==AOK && !m_exc && !w_exc. For mul: at DONE->M write, else at accept.
//  OF: add/sub signed overflow; and/xor 0; mul 1 if 2*DATA_W product is not sign-ext of low half.
//  Non-AOK e_stat: passes through to M_stat, no CC update, valE still computed.
//  Any M_stat != AOK inhibits no further writes here (memory stage owns that).
//  Forward: IDLE accept non-mul -> fwd_dstE/valE of that instr, fwd_valid 1.
//  During MUL/DONE: fwd_dstE = latched dstE, fwd_valid 0. Else 4'hF, 0.
//  e_valid with !e_ready: inputs must be held by decode; no capture.
// TESTING
//  Reset: rst_n=0 2 cycles -> M_valid 0, cc 100, e_ready 1.
//  OPq add valA=1,valB=7FFF..FF -> M_valE 8000..00, cc {0,1,1}, 1-cycle latency.
//  mulq valA=-3,valB=5 -> e_ready 0 for DATA_W+1 cycles, M_valE -15, cc {0,1,0};
//   A=B=2^32 -> OF 1.
//  cmovle after sub 5-5 (ZF=1) -> M_dstE kept; after cc {0,0,0} -> M_dstE F.
//  m_ready=0 with M_valid 1 -> e_ready 0, M_* stable; m_ready=1 -> next instr captured same edge.
//  m_exc=1 during OPq -> cc unchanged; rst_n=0 mid-MUL -> state IDLE, M_valid 0.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Y86 execute stage: ALU, condition codes, branch/cmov condition, E->M register.
// Adds an iterative signed mulq (OPq ifun 4) with valid/ready stalls on both sides.
// Ports: clk, rst_n (sync, active low); E side e_valid/e_ready plus e_* fields;
//   m_exc/w_exc inhibit CC; fwd_* taps to decode; cc {ZF,SF,OF}; M side M_* + m_ready.
module execute_stage_mc #(
  parameter int DATA_W     = 64,
  parameter bit MUL_EN     = 1'b1,
  parameter int STACK_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [3:0]        e_stat,
  input  logic [DATA_W-1:0] e_valA,
  input  logic [DATA_W-1:0] e_valB,
  input  logic [DATA_W-1:0] e_valC,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        e_dstM,
  input  logic              m_exc,
  input  logic              w_exc,
  output logic [3:0]        fwd_dstE,
  output logic [DATA_W-1:0] fwd_valE,
  output logic              fwd_valid,
  output logic [2:0]        cc,
  output logic              M_valid,
  input  logic              m_ready,
  output logic [3:0]        M_icode,
  output logic [3:0]        M_stat,
  output logic              M_cnd,
  output logic [DATA_W-1:0] M_valE,
  output logic [DATA_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam int W  = DATA_W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] STEP = W'(STACK_STEP);
  localparam logic [3:0] AOK = 4'd1;
  localparam logic [3:0] INS = 4'd4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
  state_t state, state_n;

  logic zf, sf, of;
  assign {zf, sf, of} = cc;

  logic is_cmov, is_jxx, is_op, is_mul, op_bad;
  logic cond, cond_bad, accept, m_free, ex_wr, mul_wr;
  logic [W-1:0] sum, diff, val_e;
  logic of_n;
  logic [3:0] ex_stat, ex_dstE;
  logic ex_cnd, cc_ok;

  assign is_cmov = (e_icode == 4'h2);
  assign is_jxx  = (e_icode == 4'h7);
  assign is_op   = (e_icode == 4'h6);
  assign is_mul  = MUL_EN && is_op && (e_ifun == 4'h4);
  assign op_bad  = is_op && ((e_ifun > 4'h4) ||
                   ((e_ifun == 4'h4) && !MUL_EN));

  assign m_free  = !M_valid || m_ready;
  assign e_ready = (state == S_IDLE) && m_free;
  assign accept  = e_valid && e_ready;
  assign ex_wr   = accept && !is_mul;
  assign mul_wr  = (state == S_DONE) && m_free;

  always_comb begin
    cond = 1'b0;
    cond_bad = 1'b0;
    unique case (e_ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = (sf ^ of) | zf;
      4'h2: cond = sf ^ of;
      4'h3: cond = zf;
      4'h4: cond = !zf;
      4'h5: cond = !(sf ^ of);
      4'h6: cond = !(sf ^ of) && !zf;
      default: cond_bad = 1'b1;
    endcase
  end

  assign sum  = e_valB + e_valA;
  assign diff = e_valB - e_valA;

  always_comb begin
    val_e = '0;
    of_n = 1'b0;
    unique case (e_icode)
      4'h2: val_e = e_valA;
      4'h3: val_e = e_valC;
      4'h4, 4'h5: val_e = e_valB + e_valC;
      4'h8, 4'hA: val_e = e_valB - STEP;
      4'h9, 4'hB: val_e = e_valB + STEP;
      4'h6: begin
        unique case (e_ifun)
          4'h0: begin
            val_e = sum;
            of_n = (e_valA[W-1] == e_valB[W-1]) &&
                   (sum[W-1] != e_valB[W-1]);
          end
          4'h1: begin
            val_e = diff;
            of_n = (e_valA[W-1] != e_valB[W-1]) &&
                   (diff[W-1] != e_valB[W-1]);
          end
          4'h2: val_e = e_valA & e_valB;
          4'h3: val_e = e_valA ^ e_valB;
          default: val_e = '0;
        endcase
      end
      default: val_e = '0;
    endcase
  end

  assign ex_cnd  = (is_cmov || is_jxx) ? cond : 1'b1;
  assign ex_dstE = (is_cmov && !cond) ? RNONE : e_dstE;

  always_comb begin
    ex_stat = e_stat;
    if (e_stat == AOK &&
        (((is_cmov || is_jxx) && cond_bad) || op_bad))
      ex_stat = INS;
  end

  assign cc_ok = !m_exc && !w_exc;

  // Multiplier: magnitudes shift-add, sign applied once iteration completes.
  logic [2*W-1:0] mcand, acc, prod;
  logic [W-1:0]   mplier, a_mag, b_mag, mul_valA;
  logic [3:0]     mul_stat, mul_dstE, mul_dstM;
  logic           mul_neg, mul_of;
  logic [CW-1:0]  cnt;

  assign a_mag  = e_valA[W-1] ? -e_valA : e_valA;
  assign b_mag  = e_valB[W-1] ? -e_valB : e_valB;
  assign prod   = mul_neg ? -acc : acc;
  assign mul_of = prod[2*W-1:W] != {W{prod[W-1]}};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept && is_mul) state_n = S_MUL;
      S_MUL:  if (cnt == CW'(W - 1)) state_n = S_DONE;
      S_DONE: if (m_free) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept && is_mul) begin
      mcand    <= {{W{1'b0}}, a_mag};
      mplier   <= b_mag;
      acc      <= '0;
      mul_neg  <= e_valA[W-1] ^ e_valB[W-1];
      mul_stat <= ex_stat;
      mul_dstE <= e_dstE;
      mul_dstM <= e_dstM;
      mul_valA <= e_valA;
      cnt      <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      M_valid <= 1'b0;
      M_icode <= '0;
      M_stat  <= '0;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= '0;
      M_dstM  <= '0;
      cc      <= 3'b100;
    end else if (ex_wr) begin
      M_valid <= 1'b1;
      M_icode <= e_icode;
      M_stat  <= ex_stat;
      M_cnd   <= ex_cnd;
      M_valE  <= val_e;
      M_valA  <= e_valA;
      M_dstE  <= ex_dstE;
      M_dstM  <= e_dstM;
      if (is_op && ex_stat == AOK && cc_ok)
        cc <= {val_e == '0, val_e[W-1], of_n};
    end else if (mul_wr) begin
      M_valid <= 1'b1;
      M_icode <= 4'h6;
      M_stat  <= mul_stat;
      M_cnd   <= 1'b1;
      M_valE  <= prod[W-1:0];
      M_valA  <= mul_valA;
      M_dstE  <= mul_dstE;
      M_dstM  <= mul_dstM;
      if (mul_stat == AOK && cc_ok)
        cc <= {prod[W-1:0] == '0, prod[W-1], mul_of};
    end else if (m_ready) begin
      M_valid <= 1'b0;
    end
  end

  always_comb begin
    fwd_dstE  = RNONE;
    fwd_valE  = '0;
    fwd_valid = 1'b0;
    if (state != S_IDLE) begin
      fwd_dstE = mul_dstE;
    end else if (ex_wr) begin
      fwd_dstE  = ex_dstE;
      fwd_valE  = val_e;
      fwd_valid = 1'b1;
    end
  end

endmodule
